// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple-counter value, accepts it only after it has stayed stable,
// and counts the wraps of the accepted value.
module ripple_count_sampler #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned WRAP_WIDTH    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [WIDTH-1:0]      i_count_in,
  input  logic                  i_clear_wrap,
  output logic [WIDTH-1:0]      o_count_out,
  output logic                  o_count_valid,
  output logic                  o_wrap_pulse,
  output logic [WRAP_WIDTH-1:0] o_wrap_count,
  output logic                  o_wrap_sat
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  logic [WIDTH-1:0]      r_sync1;
  logic [WIDTH-1:0]      r_sync2;
  logic [WIDTH-1:0]      r_cand;
  logic [WIDTH-1:0]      r_count;
  logic [STAB_W-1:0]     r_stab;
  state_t                r_state;
  logic                  r_valid;
  logic                  r_wrap;
  logic [WRAP_WIDTH-1:0] r_wrap_cnt;
  logic                  r_wrap_sat;

  logic                  w_match;
  logic                  w_stab_done;
  logic                  w_accept;
  logic                  w_new;
  logic                  w_wrap;
  logic [WRAP_WIDTH-1:0] w_wrap_next;

  // Two-flop synchronizer, always running so it is warm when enable rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_count_in;
      r_sync2 <= r_sync1;
    end
  end

  // The confirming sample that brings stab up to STABLE_CYCLES is the accepting edge.
  always_comb begin
    w_match     = (r_sync2 == r_cand);
    w_stab_done = (r_stab == STAB_W'(STABLE_CYCLES - 1));
    w_accept    = i_enable && (r_state == SETTLE) && w_match && w_stab_done;
    w_new       = w_accept && (r_cand != r_count);
    w_wrap      = w_new && (r_cand < r_count);
    w_wrap_next = r_wrap_cnt;
    if (w_wrap && !(&r_wrap_cnt)) begin
      w_wrap_next = r_wrap_cnt + WRAP_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_stab  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      if (i_enable) begin
        if (!w_match) begin
          r_cand  <= r_sync2;
          r_stab  <= '0;
          r_state <= SETTLE;
        end else if (r_state == SETTLE) begin
          if (w_stab_done) begin
            r_state <= IDLE;
            r_stab  <= '0;
            if (w_new) begin
              r_count <= r_cand;
              r_valid <= 1'b1;
            end
            r_wrap <= w_wrap;
          end else begin
            r_stab <= r_stab + STAB_W'(1);
          end
        end
      end
    end
  end

  // Saturating wrap counter; a clear takes priority over a coincident wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrap_cnt <= '0;
      r_wrap_sat <= 1'b0;
    end else if (i_clear_wrap) begin
      r_wrap_cnt <= '0;
      r_wrap_sat <= 1'b0;
    end else begin
      r_wrap_cnt <= w_wrap_next;
      r_wrap_sat <= &w_wrap_next;
    end
  end

  assign o_count_out   = r_count;
  assign o_count_valid = r_valid;
  assign o_wrap_pulse  = r_wrap;
  assign o_wrap_count  = r_wrap_cnt;
  assign o_wrap_sat    = r_wrap_sat;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler with a 2-bit wrap counter to reach saturation quickly.
module tb_ripple_count_sampler;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned WRAP_WIDTH = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [WIDTH-1:0]      count_in;
  logic                  clear_wrap;
  logic [WIDTH-1:0]      count_out;
  logic                  count_valid;
  logic                  wrap_pulse;
  logic [WRAP_WIDTH-1:0] wrap_count;
  logic                  wrap_sat;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_wrap   = 0;
  int n_coinc  = 0;
  int v0;
  int w0;
  int c0;

  ripple_count_sampler #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(2),
    .WRAP_WIDTH(WRAP_WIDTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(enable),
    .i_count_in(count_in),
    .i_clear_wrap(clear_wrap),
    .o_count_out(count_out),
    .o_count_valid(count_valid),
    .o_wrap_pulse(wrap_pulse),
    .o_wrap_count(wrap_count),
    .o_wrap_sat(wrap_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (count_valid) n_valid++;
    if (wrap_pulse) n_wrap++;
    if (wrap_pulse && count_valid) n_coinc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Value 15 then 0; the 0 is accepted at the 5th edge after it is driven.
  task automatic wrap_cycle(input bit clr, input int exp_cnt, input bit exp_sat);
    count_in = 4'd15;
    tick(8);
    check("wrap_hi_count", 32'(count_out), 32'd15);
    count_in = 4'd0;
    tick(4);
    clear_wrap = clr;
    tick(1);
    clear_wrap = 1'b0;
    check("wrap_valid", 32'(count_valid), 32'd1);
    check("wrap_pulse", 32'(wrap_pulse), 32'd1);
    check("wrap_count", 32'(wrap_count), 32'(exp_cnt));
    check("wrap_sat", 32'(wrap_sat), 32'(exp_sat));
    tick(3);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    count_in   = '0;
    clear_wrap = 1'b0;
    #23;
    check("rst_count_out", 32'(count_out), 32'd0);
    check("rst_valid", 32'(count_valid), 32'd0);
    check("rst_wrap_count", 32'(wrap_count), 32'd0);
    check("rst_wrap_sat", 32'(wrap_sat), 32'd0);
    rst_n = 1'b1;
    tick(8);
    check("post_rst_no_valid", 32'(n_valid), 32'd0);

    // Step 0 -> 5: update lands at edge n+4.
    count_in = 4'd5;
    tick(4);
    check("lat_not_yet", 32'(count_out), 32'd0);
    tick(1);
    check("lat_count_out", 32'(count_out), 32'd5);
    check("lat_valid", 32'(count_valid), 32'd1);
    check("lat_no_wrap", 32'(wrap_pulse), 32'd0);
    tick(1);
    check("lat_valid_1cyc", 32'(count_valid), 32'd0);

    // One-cycle glitch to 4 settles back to 5.
    v0 = n_valid;
    count_in = 4'd4;
    tick(1);
    count_in = 4'd5;
    tick(10);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_count_out", 32'(count_out), 32'd5);
    check("glitch_idle", 32'(dut.r_state), 32'd0);

    // Five wraps into a 2-bit counter; clear on the fifth.
    v0 = n_valid;
    w0 = n_wrap;
    c0 = n_coinc;
    wrap_cycle(1'b0, 1, 1'b0);
    check("wrap1_valids", 32'(n_valid - v0), 32'd2);
    check("wrap1_pulses", 32'(n_wrap - w0), 32'd1);
    check("wrap1_coinc", 32'(n_coinc - c0), 32'd1);
    wrap_cycle(1'b0, 2, 1'b0);
    wrap_cycle(1'b0, 3, 1'b1);
    wrap_cycle(1'b0, 3, 1'b1);
    wrap_cycle(1'b1, 0, 1'b0);

    // Freeze with stab=1, resume needs one more confirming edge.
    v0 = n_valid;
    count_in = 4'd9;
    tick(4);
    check("frz_settle", 32'(dut.r_state), 32'd1);
    check("frz_stab", 32'(dut.r_stab), 32'd1);
    enable = 1'b0;
    tick(10);
    check("frz_no_valid", 32'(n_valid - v0), 32'd0);
    check("frz_count_out", 32'(count_out), 32'd0);
    check("frz_stab_held", 32'(dut.r_stab), 32'd1);
    enable = 1'b1;
    tick(1);
    check("resume_count_out", 32'(count_out), 32'd9);
    check("resume_valid", 32'(count_valid), 32'd1);

    // Reset mid-SETTLE.
    tick(2);
    v0 = n_valid;
    count_in = 4'd3;
    tick(3);
    check("mid_settle", 32'(dut.r_state), 32'd1);
    rst_n = 1'b0;
    #2;
    check("async_count_out", 32'(count_out), 32'd0);
    check("async_valid", 32'(count_valid), 32'd0);
    check("async_state", 32'(dut.r_state), 32'd0);
    count_in = 4'd0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("rel_no_valid", 32'(n_valid - v0), 32'd0);
    check("rel_count_out", 32'(count_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 Parameter WIDTH, default 4, is the width of the ripple-counter value consumed.
REQ-002 Parameter STABLE_CYCLES, default 2 (legal 1..15), is the number of consecutive confirming samples required before a new value is accepted.
REQ-003 Parameter WRAP_WIDTH, default 8, is the width of the wrap counter.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets the block immediately.
REQ-006 enable  input  1  1 = sampling and acceptance active; 0 = FSM frozen.
REQ-007 count_in  input  WIDTH  Q outputs of the upstream asynchronous JK ripple counter (bit 0 = LSB); asynchronous to clock.
REQ-008 clear_wrap  input  1  synchronous clear of wrap_count and wrap_sat.
REQ-009 count_out  output  WIDTH  last accepted, glitch-free count value (registered).
REQ-010 count_valid  output  1  one-cycle pulse when count_out takes a new value.
REQ-011 wrap_pulse  output  1  one-cycle pulse when the accepted value is numerically lower than the previous count_out.
REQ-012 wrap_count  output  WRAP_WIDTH  number of wraps seen, saturating.
REQ-013 wrap_sat  output  1  high while wrap_count is all ones.

Function
REQ-014 count_in shall pass through a two-flop synchronizer (sync1, then sync2) every cycle, regardless of enable.
REQ-015 The FSM shall have two states: IDLE (candidate equals count_out) and SETTLE (candidate under confirmation, stab counter running).
REQ-016 With enable=1, at an edge where sync2 differs from the candidate register, the block shall load candidate with sync2, clear stab to 0, and enter SETTLE; this applies from either state.
REQ-017 In SETTLE with enable=1, each edge where sync2 equals candidate shall increment stab; at the edge where stab reaches STABLE_CYCLES, the block shall accept and return to IDLE.
REQ-018 On acceptance with candidate different from count_out, the block shall load count_out with candidate and assert count_valid for exactly the following cycle.
REQ-019 On acceptance with candidate equal to count_out (a glitch that settled back), the block shall produce no count_valid or wrap_pulse and shall return to IDLE.
REQ-020 Latency shall be STABLE_CYCLES+2 edges: with count_in stable before edge n, count_out updates at edge n+STABLE_CYCLES+2 (n+4 by default).
REQ-021 wrap_pulse shall assert in the same cycle as count_valid whenever the new count_out is less than the old count_out as an unsigned value (for example, 15 to 0).
REQ-022 Each wrap_pulse shall increment wrap_count by 1; wrap_count shall saturate at 2^WRAP_WIDTH-1 and never roll over.
REQ-023 wrap_sat shall equal the AND-reduction of wrap_count, registered in the same cycle as wrap_count.
REQ-024 clear_wrap=1 shall set wrap_count to 0 and wrap_sat to 0 at the next edge; clear shall win over a simultaneous wrap event, and wrap_pulse shall still assert.
REQ-025 With enable=0, the block shall hold state, candidate, stab and count_out, and shall force count_valid=0 and wrap_pulse=0; the synchronizer and clear_wrap shall stay active.
REQ-026 When enable returns to 1, the block shall resume from the frozen state and stab value.
REQ-027 The stab counter shall be wide enough for STABLE_CYCLES and shall never overflow.

Reset
REQ-028 While reset=0, the block shall asynchronously set sync1, sync2, candidate, count_out and stab to 0, set the state to IDLE, and drive count_valid, wrap_pulse, wrap_count and wrap_sat to 0.
REQ-029 Reset asserted mid-SETTLE shall discard the candidate without any pulse.
REQ-030 After reset release with count_in=0, the block shall produce no count_valid.

Verification
REQ-031 Reset release, count_in stepped 0 to 5 before edge n, enable=1 -> count_out=5 and count_valid=1 in the cycle after edge n+4; no wrap_pulse.
REQ-032 count_in at 5, a 1-cycle glitch to 4, then back to 5 -> no count_valid; count_out stays 5; state returns to IDLE.
REQ-033 count_in stepped 15 then 0, each held 8 cycles -> two count_valid pulses, wrap_pulse coincides with the second, and wrap_count=1.
REQ-034 WRAP_WIDTH=2 with 5 wraps -> wrap_count=3 and wrap_sat=1 after the third wrap and thereafter; clear_wrap on the 5th wrap edge -> wrap_count=0.
REQ-035 enable=0 during SETTLE for 10 cycles -> no count_valid while low; acceptance occurs STABLE_CYCLES minus the stab value already reached, counted in edges after enable=1.
REQ-036 reset pulsed low mid-SETTLE -> all outputs 0 immediately, with no pulse after release.
